// File: rtl/gated_rca_pkg.sv
// Shared types and sizing helpers for the gated, pipelined ripple-carry adder.
package gated_rca_pkg;

  typedef enum logic [1:0] {IDLE, WAKE, ACTIVE} fsm_state_t;

  localparam int unsigned MAX_STAGES = 4;

  function automatic int unsigned seg_width(input int unsigned width, input int unsigned stages);
    return width / stages;
  endfunction

  // Width of a counter holding 0 .. idle_cycles-1 (never narrower than one bit).
  function automatic int unsigned idle_cnt_width(input int unsigned idle_cycles);
    return (idle_cycles <= 2) ? 1 : $clog2(idle_cycles);
  endfunction

endpackage

// File: rtl/clock_gating_cell.sv
// Latch-based integrated clock gate: enable is captured while clk is low so gclk never glitches.
module clock_gating_cell (
  input  logic clk,
  input  logic en,
  output logic gclk
);

  logic en_lat;

  always_latch begin
    if (!clk) en_lat = en;
  end

  assign gclk = clk & en_lat;

endmodule

// File: rtl/rca_pipe_stage.sv
// One carry segment of the pipelined adder: segment add plus operand/sum/carry registers on the gated
// clock, and the stage valid bit on the free-running clock.
module rca_pipe_stage #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned SEG    = 8,
  parameter int unsigned OFFSET = 0,
  parameter int unsigned APPROX = 0
) (
  input  logic             clk,
  input  logic             gclk,
  input  logic             rst,
  input  logic             adv,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] sum_in,
  input  logic             carry_in,
  output logic             valid_q,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic [WIDTH-1:0] sum_q,
  output logic             carry_q
);

  logic [SEG-1:0]   a_seg;
  logic [SEG-1:0]   b_seg;
  logic [SEG-1:0]   s_seg;
  logic [WIDTH-1:0] sum_next;
  logic             rc;
  logic             c_out;

  assign a_seg = a_in[OFFSET +: SEG];
  assign b_seg = b_in[OFFSET +: SEG];

  // Approximate bits are plain ORs; the last one's AND becomes the carry into the exact part.
  always_comb begin
    rc    = carry_in;
    s_seg = '0;
    for (int unsigned i = 0; i < SEG; i++) begin
      if (i < APPROX) begin
        s_seg[i] = a_seg[i] | b_seg[i];
        rc       = a_seg[i] & b_seg[i];
      end else begin
        s_seg[i] = a_seg[i] ^ b_seg[i] ^ rc;
        rc       = (a_seg[i] & b_seg[i]) | (rc & (a_seg[i] ^ b_seg[i]));
      end
    end
    c_out = rc;
  end

  always_comb begin
    sum_next                = sum_in;
    sum_next[OFFSET +: SEG] = s_seg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     valid_q <= 1'b0;
    else if (adv) valid_q <= valid_in;
  end

  always_ff @(posedge gclk or negedge rst) begin
    if (!rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      a_q     <= a_in;
      b_q     <= b_in;
      sum_q   <= sum_next;
      carry_q <= c_out;
    end
  end

endmodule

// File: rtl/gated_pipe_rca.sv
// Pipelined segmented (optionally LOA-approximate) ripple-carry adder with per-stage clock gating,
// global stall and an idle FSM. Define GATED_RCA_STATS_EN to add the gated_cycles counter port.
module gated_pipe_rca
  import gated_rca_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned APPROX      = 0,
  parameter int unsigned STAGES      = 2,
  parameter int unsigned IDLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef GATED_RCA_STATS_EN
  ,
  output logic [31:0]      gated_cycles
`endif
);

  localparam int unsigned SEG   = seg_width(WIDTH, STAGES);
  localparam int unsigned CNT_W = idle_cnt_width(IDLE_CYCLES);

  if ((STAGES < 1) || (STAGES > MAX_STAGES) || (WIDTH % STAGES != 0) ||
      (APPROX >= SEG) || (IDLE_CYCLES < 1)) begin : g_bad_cfg
    $error("gated_pipe_rca: illegal WIDTH/STAGES/APPROX/IDLE_CYCLES combination");
  end

  fsm_state_t        state, state_next;
  logic [CNT_W-1:0]  idle_cnt, idle_cnt_next;
  logic              pipe_empty;
  logic              advance;
  logic              accept;

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] ven;
  logic [STAGES-1:0] en;
  logic [STAGES-1:0] gclk;
  logic [WIDTH-1:0]  a_pipe   [STAGES+1];
  logic [WIDTH-1:0]  b_pipe   [STAGES+1];
  logic [WIDTH-1:0]  sum_pipe [STAGES+1];
  logic              c_pipe   [STAGES+1];
  logic              unused_tail;

  assign out_valid = v[STAGES-1];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance && (state == ACTIVE);
  assign accept    = in_valid && in_ready;

  assign a_pipe[0]   = a;
  assign b_pipe[0]   = b;
  assign sum_pipe[0] = '0;
  assign c_pipe[0]   = cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign ven[k] = accept;
    end else begin : g_tail
      assign ven[k] = v[k-1];
    end

    // A stage only clocks its data when a beat is actually moving into it.
    assign en[k] = advance && ven[k] && (state != IDLE);

    clock_gating_cell u_cg (
      .clk  (clk),
      .en   (en[k]),
      .gclk (gclk[k])
    );

    rca_pipe_stage #(
      .WIDTH  (WIDTH),
      .SEG    (SEG),
      .OFFSET (k * SEG),
      .APPROX ((k == 0) ? APPROX : 0)
    ) u_stage (
      .clk      (clk),
      .gclk     (gclk[k]),
      .rst      (rst),
      .adv      (advance),
      .valid_in (ven[k]),
      .a_in     (a_pipe[k]),
      .b_in     (b_pipe[k]),
      .sum_in   (sum_pipe[k]),
      .carry_in (c_pipe[k]),
      .valid_q  (v[k]),
      .a_q      (a_pipe[k+1]),
      .b_q      (b_pipe[k+1]),
      .sum_q    (sum_pipe[k+1]),
      .carry_q  (c_pipe[k+1])
    );
  end

  assign sum         = sum_pipe[STAGES];
  assign cout        = c_pipe[STAGES];
  assign unused_tail = ^{a_pipe[STAGES], b_pipe[STAGES]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      idle_cnt <= '0;
    end else begin
      state    <= state_next;
      idle_cnt <= idle_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    idle_cnt_next = '0;
    pipe_empty    = (v == '0) && !in_valid;
    case (state)
      IDLE:   if (in_valid) state_next = WAKE;
      WAKE:   state_next = ACTIVE;
      ACTIVE: begin
        if (pipe_empty) begin
          if (idle_cnt == CNT_W'(IDLE_CYCLES - 1)) state_next = IDLE;
          else                                     idle_cnt_next = idle_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef GATED_RCA_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                               gated_cycles <= '0;
    else if (!en[0] && (gated_cycles != '1)) gated_cycles <= gated_cycles + 32'd1;
  end
`endif

endmodule
